// File: rtl/lvds_pkg.sv
// Shared definitions for the LVDS transmit serializer.
//   lvds_state_e      : framing FSM state encoding
//   Channels*/Factor* : legal ranges for CHANNELS and FACTOR
//   TrainWordDefault  : default per-lane training pattern
//   UnderrunSat       : saturation value of the underrun counter
//   clk_high_bits()   : number of leading bit slots with tx_outclock high
package lvds_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } lvds_state_e;

    localparam int unsigned ChannelsMin = 1;
    localparam int unsigned ChannelsMax = 8;
    localparam int unsigned FactorMin   = 4;
    localparam int unsigned FactorMax   = 10;

    localparam logic [7:0] TrainWordDefault = 8'hA5;
    localparam logic [7:0] UnderrunSat      = 8'hFF;

    // Forwarded clock is high for ceil(factor/2) bit slots.
    function automatic int unsigned clk_high_bits(input int unsigned factor);
        return (factor + 1) / 2;
    endfunction

endpackage

// File: rtl/lvds_lane_shift.sv
// One lane of the serializer: a FACTOR-bit parallel-load shift register.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture din this cycle instead of shifting
//   din        : parallel word for this lane
//   dout       : registered serial bit (bit FACTOR-1 or bit 0 of the register)
module lvds_lane_shift #(
    parameter int unsigned FACTOR    = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [FACTOR-1:0] din,
    output logic              dout
);

    logic [FACTOR-1:0] shift_q, shift_d;

    // Zeros are shifted in, so an emptied register naturally idles at 0.
    always_comb begin
        shift_d = shift_q;
        if (load) begin
            shift_d = din;
        end else if (MSB_FIRST) begin
            shift_d = {shift_q[FACTOR-2:0], 1'b0};
        end else begin
            shift_d = {1'b0, shift_q[FACTOR-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign dout = MSB_FIRST ? shift_q[FACTOR-1] : shift_q[0];

endmodule

// File: rtl/lvds_tx_ser.sv
// Multi-lane LVDS transmit serializer with forwarded frame clock.
//   clk, rst_n   : bit clock, asynchronous active-low reset
//   enable       : run framing; dropping it stops at the next frame boundary
//   train_en     : send TRAIN_WORD on all lanes at each frame load
//   tx_in        : parallel words, lane k at [k*FACTOR +: FACTOR]
//   tx_valid     : tx_in holds a word
//   tx_ready     : word accepted into the holding buffer this cycle
//   tx_out       : serial data, one bit per lane (registered)
//   tx_outclock  : forwarded frame clock (registered)
//   frame_start  : high with the first bit of every frame (registered)
//   underrun_cnt : saturating count of frames loaded with no data
module lvds_tx_ser
    import lvds_pkg::*;
#(
    parameter int unsigned       CHANNELS   = 2,
    parameter int unsigned       FACTOR     = 8,
    parameter bit                MSB_FIRST  = 1'b1,
    parameter logic [FACTOR-1:0] TRAIN_WORD = FACTOR'(TrainWordDefault)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         train_en,
    input  logic [CHANNELS*FACTOR-1:0]   tx_in,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [CHANNELS-1:0]          tx_out,
    output logic                         tx_outclock,
    output logic                         frame_start,
    output logic [7:0]                   underrun_cnt
);

    if (CHANNELS < ChannelsMin || CHANNELS > ChannelsMax ||
        FACTOR < FactorMin || FACTOR > FactorMax) begin : g_param_check
        $error("lvds_tx_ser: CHANNELS or FACTOR out of range");
    end

    localparam int unsigned     CntW    = $clog2(FACTOR);
    localparam logic [CntW-1:0] LastBit = CntW'(FACTOR - 1);
    localparam logic [CntW-1:0] ClkHigh = CntW'(clk_high_bits(FACTOR));

    lvds_state_e                 state_q, state_d;
    logic [CntW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                        last_bit;
    logic                        frame_load;

    logic                        buf_full_q, buf_full_d;
    logic [CHANNELS*FACTOR-1:0]  buf_q, buf_d;
    logic                        drain;
    logic                        accept;
    logic                        ready_en_q;

    logic [CHANNELS*FACTOR-1:0]  load_word;
    logic [7:0]                  underrun_q, underrun_d;
    logic                        outclock_q, outclock_d;
    logic                        frame_start_q, frame_start_d;

    // Framing FSM. Entering RUN presets bit_cnt to the last slot so the
    // first RUN cycle is itself a frame-load slot.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (enable) begin
                    state_d   = StRun;
                    bit_cnt_d = LastBit;
                end
            end
            StRun: begin
                if (bit_cnt_q == LastBit) begin
                    bit_cnt_d = '0;
                    if (!enable) begin
                        state_d = StIdle;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
    end

    assign last_bit   = (state_q == StRun) && (bit_cnt_q == LastBit);
    assign frame_load = last_bit && enable;

    // Training has priority and leaves a held word in place for later.
    assign drain    = frame_load && !train_en && buf_full_q;
    assign tx_ready = ready_en_q && (!buf_full_q || drain);
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end
        // A same-cycle accept wins over the drain: the buffer refills.
        if (accept) begin
            buf_full_d = 1'b1;
            buf_d      = tx_in;
        end
    end

    // Lanes load on every last slot; when leaving RUN they load zeros,
    // which parks tx_out at 0 for IDLE.
    always_comb begin
        load_word = '0;
        if (frame_load) begin
            if (train_en) begin
                load_word = {CHANNELS{TRAIN_WORD}};
            end else if (buf_full_q) begin
                load_word = buf_q;
            end
        end
    end

    always_comb begin
        underrun_d = underrun_q;
        if (frame_load && !train_en && !buf_full_q && underrun_q != UnderrunSat) begin
            underrun_d = underrun_q + 8'd1;
        end
    end

    // Outputs are registered from next-state values so they line up with
    // the lane registers: slot p of a frame is on the wire while bit_cnt=p.
    assign frame_start_d = frame_load;
    assign outclock_d    = (state_d == StRun) && (bit_cnt_d < ClkHigh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            buf_full_q    <= 1'b0;
            buf_q         <= '0;
            ready_en_q    <= 1'b0;
            underrun_q    <= '0;
            outclock_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            buf_full_q    <= buf_full_d;
            buf_q         <= buf_d;
            ready_en_q    <= 1'b1;
            underrun_q    <= underrun_d;
            outclock_q    <= outclock_d;
            frame_start_q <= frame_start_d;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        lvds_lane_shift #(
            .FACTOR   (FACTOR),
            .MSB_FIRST(MSB_FIRST)
        ) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .load (last_bit),
            .din  (load_word[k*FACTOR +: FACTOR]),
            .dout (tx_out[k])
        );
    end

    assign tx_outclock  = outclock_q;
    assign frame_start  = frame_start_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_lvds_tx_ser.sv
// Bench for lvds_tx_ser: a 2-lane/8-bit MSB-first instance checked through a
// frame scoreboard, plus a 1-lane/7-bit LSB-first instance checked directly.
module tb_lvds_tx_ser;

    logic        clk;
    logic        rst_n;
    logic        enable, train_en, tx_valid, tx_ready;
    logic [15:0] tx_in;
    logic [1:0]  tx_out;
    logic        tx_outclock, frame_start;
    logic [7:0]  underrun_cnt;

    logic        enable7, train_en7, tx_valid7, tx_ready7;
    logic [6:0]  tx_in7;
    logic [0:0]  tx_out7;
    logic        tx_outclock7, frame_start7;
    logic [7:0]  underrun_cnt7;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    int          mon_idx;
    bit          mon_active;
    logic [15:0] mon_want, mon_obs;
    logic [7:0]  mon_clk;

    logic [27:0] seq_out, seq_clk, seq_fs;

    lvds_tx_ser u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .train_en    (train_en),
        .tx_in       (tx_in),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_out      (tx_out),
        .tx_outclock (tx_outclock),
        .frame_start (frame_start),
        .underrun_cnt(underrun_cnt)
    );

    lvds_tx_ser #(
        .CHANNELS (1),
        .FACTOR   (7),
        .MSB_FIRST(1'b0)
    ) u_dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable7),
        .train_en    (train_en7),
        .tx_in       (tx_in7),
        .tx_valid    (tx_valid7),
        .tx_ready    (tx_ready7),
        .tx_out      (tx_out7),
        .tx_outclock (tx_outclock7),
        .frame_start (frame_start7),
        .underrun_cnt(underrun_cnt7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Offer a word on the main instance; optionally queue it as the next frame.
    task automatic send(input logic [15:0] w, input bit push);
        int n;
        n = 0;
        tx_in    = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(tx_ready), 32'd1);
        if (tx_ready === 1'b1) begin
            @(posedge clk);
            if (push) exp_q.push_back(w);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 40);
        chk("frame_start_seen", 32'(frame_start), 32'd1);
    endtask

    // Scoreboard: each frame pops its expected lane words (zeros when nothing
    // is queued, i.e. an underrun frame) and is compared after its 8th bit.
    initial begin
        mon_idx    = 0;
        mon_active = 1'b0;
        mon_want   = '0;
        mon_obs    = '0;
        mon_clk    = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
                mon_idx    = 0;
            end else begin
                if (frame_start === 1'b1) begin
                    if (exp_q.size() > 0) mon_want = exp_q.pop_front();
                    else mon_want = 16'h0000;
                    mon_active = 1'b1;
                    mon_idx    = 0;
                    mon_obs    = '0;
                    mon_clk    = '0;
                end
                if (mon_active) begin
                    for (int k = 0; k < 2; k++) begin
                        mon_obs[k*8 +: 8] = {mon_obs[k*8 +: 7], tx_out[k]};
                    end
                    mon_clk = {mon_clk[6:0], tx_outclock};
                    mon_idx++;
                    if (mon_idx == 8) begin
                        chk("frame_data", 32'(mon_obs), 32'(mon_want));
                        chk("frame_outclock", 32'(mon_clk), 32'h0000_00F0);
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;  enable = 1'b0;  train_en = 1'b0;  tx_valid = 1'b0;  tx_in = '0;
        enable7 = 1'b0;  train_en7 = 1'b0;  tx_valid7 = 1'b0;  tx_in7 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_out", 32'(tx_out), 32'd0);
        chk("rst_outclock", 32'(tx_outclock), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_underrun", 32'(underrun_cnt), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(tx_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_release", 32'(tx_ready), 32'd1);

        // Back-to-back words, enable raised with the first accept
        enable = 1'b1;
        send({8'h22, 8'h11}, 1'b1);
        chk("no_start_in_load_cycle", 32'(frame_start), 32'd0);
        send({8'h34, 8'h12}, 1'b1);
        chk("first_word_latency", 32'(frame_start), 32'd1);
        chk("ready_low_buffer_full", 32'(tx_ready), 32'd0);
        send({8'h5A, 8'hC0}, 1'b1);

        // Underruns: three empty frames after the last word, then saturation
        repeat (4) wait_fs();
        chk("underrun_three", 32'(underrun_cnt), 32'd3);
        chk("underrun_tx_out", 32'(tx_out), 32'd0);
        repeat (300) wait_fs();
        chk("underrun_saturated", 32'(underrun_cnt), 32'd255);

        // Training raised mid-frame with a word pending in the buffer
        send({8'hC3, 8'h3C}, 1'b1);
        send({8'h0F, 8'hF0}, 1'b0);
        repeat (3) @(negedge clk);
        train_en = 1'b1;
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(16'hA5A5);
        repeat (8) @(negedge clk);
        chk("train_keeps_buffer", 32'(tx_ready), 32'd0);
        repeat (8) @(negedge clk);
        train_en = 1'b0;
        exp_q.push_back({8'h0F, 8'hF0});
        repeat (2) wait_fs();

        // Reset asserted at bit 3 of a frame
        send({8'h99, 8'h66}, 1'b1);
        wait_fs();
        repeat (3) @(negedge clk);
        chk("bit3_tx_out", 32'(tx_out), 32'h2);
        chk("bit3_outclock", 32'(tx_outclock), 32'd1);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("midrst_tx_out", 32'(tx_out), 32'd0);
        chk("midrst_outclock", 32'(tx_outclock), 32'd0);
        chk("midrst_frame_start", 32'(frame_start), 32'd0);
        chk("midrst_underrun", 32'(underrun_cnt), 32'd0);
        chk("midrst_ready", 32'(tx_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_hold", 32'(tx_ready), 32'd0);
        @(negedge clk);
        chk("midrst_ready_rise", 32'(tx_ready), 32'd1);
        repeat (20) @(negedge clk);
        chk("idle_underrun", 32'(underrun_cnt), 32'd0);
        chk("idle_tx_out", 32'(tx_out), 32'd0);
        chk("idle_outclock", 32'(tx_outclock), 32'd0);

        // FACTOR=7, LSB first, single lane; enable dropped mid 4th frame
        tx_in7    = 7'h11;
        tx_valid7 = 1'b1;
        enable7   = 1'b1;
        chk("f7_ready", 32'(tx_ready7), 32'd1);
        @(posedge clk);
        @(negedge clk);
        tx_valid7 = 1'b0;
        chk("f7_no_early_start", 32'(frame_start7), 32'd0);
        seq_out = '0;
        seq_clk = '0;
        seq_fs  = '0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            seq_out = {seq_out[26:0], tx_out7[0]};
            seq_clk = {seq_clk[26:0], tx_outclock7};
            seq_fs  = {seq_fs[26:0], frame_start7};
            if (i == 21) enable7 = 1'b0;
        end
        chk("f7_data", 32'(seq_out), 32'(28'b1000100_0000000_0000000_0000000));
        chk("f7_outclock", 32'(seq_clk), 32'(28'b1111000_1111000_1111000_1111000));
        chk("f7_frame_start", 32'(seq_fs), 32'(28'b1000000_1000000_1000000_1000000));
        @(negedge clk);
        chk("f7_stop_frame_start", 32'(frame_start7), 32'd0);
        chk("f7_stop_outclock", 32'(tx_outclock7), 32'd0);
        chk("f7_stop_tx_out", 32'(tx_out7), 32'd0);
        repeat (10) @(negedge clk);
        chk("f7_underrun", 32'(underrun_cnt7), 32'd3);
        chk("f7_idle_outclock", 32'(tx_outclock7), 32'd0);

        chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
